bus_dma_arbiter: RTL and testbench

- Shares the cpu65 external address/data bus between the CPU and up to N_REQ DMA requesters (video fetch, block-copy engine).
- Halts the CPU by pulling RDY low, waits until the CPU is provably stopped, then drops AEC to tri-state the CPU address/RW drivers and grants the bus to one requester.
- Sits beside the CPU wrapper in the top level. It drives the wrapper's RDY and AEC inputs in place of the pads when the on-chip DMA option is enabled.

---
 rtl/bus_dma_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bus_dma_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_arbiter.sv
// Bus arbiter for the cpu65 external bus. The CPU is halted with RDY, its
// bus drivers are released with AEC, and the bus is then granted to one of
// N_REQ DMA requesters, chosen round-robin. A turnaround cycle with gnt low
// and AEC high follows every grant, and at least one free IDLE cycle follows
// every turnaround.
module bus_dma_arbiter #(
  parameter int N_REQ     = 2,
  parameter int RDY_LEAD  = 3,
  parameter int MAX_BURST = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic             cpu_rwn,
  output logic             cpu_rdy,
  output logic             cpu_aec,
  output logic             busy,
  output logic [1:0]       last_winner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL  = 2'd1,
    S_GRANT  = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  // One counter serves both phases: stall length, then burst length.
  localparam int CNT_MAX = (RDY_LEAD > MAX_BURST) ? RDY_LEAD : MAX_BURST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LEAD_M1  = CNT_W'(RDY_LEAD - 1);
  localparam logic [CNT_W-1:0] C_BURST_M1 = CNT_W'(MAX_BURST - 1);
  localparam logic [1:0]       C_LAST_RST = 2'(N_REQ - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_winner;
  logic [1:0]       r_last;
  logic             r_rdy;
  logic             r_aec;
  logic             r_busy;
  logic [N_REQ-1:0] r_gnt;

  logic [1:0]       w_idx_hi;
  logic [1:0]       w_idx_any;
  logic             w_pick_hi;
  logic [1:0]       w_win;
  logic [N_REQ-1:0] w_win_mask;
  logic             w_req_win;
  logic             w_rdy_next;
  logic             w_aec_next;
  logic             w_busy_next;
  logic [N_REQ-1:0] w_gnt_next;

  // Round-robin pick: lowest requester above last winner, else lowest overall.
  always_comb begin
    w_idx_hi  = 2'd0;
    w_idx_any = 2'd0;
    w_pick_hi = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        w_idx_any = 2'(j);
        if (j > int'(r_last)) begin
          w_pick_hi = 1'b1;
          w_idx_hi  = 2'(j);
        end
      end
    end
    w_win = w_pick_hi ? w_idx_hi : w_idx_any;
  end

  // One-hot decode of the latched winner.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_win_mask
    assign w_win_mask[gi] = (r_winner == 2'(gi));
  end

  assign w_req_win = |(req & w_win_mask);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: halt, wait for a provably stopped CPU, grant, turn around.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|req) w_state_next = S_STALL;
      end
      S_STALL: begin
        if (!w_req_win) begin
          w_state_next = S_RETURN;
        end else if ((cpu_rwn && !r_rdy) || (r_cnt >= C_LEAD_M1)) begin
          w_state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_req_win || (r_cnt == C_BURST_M1)) w_state_next = S_RETURN;
      end
      S_RETURN: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so every output is a register.
  always_comb begin
    w_rdy_next  = (w_state_next == S_IDLE);
    w_aec_next  = (w_state_next != S_GRANT);
    w_busy_next = (w_state_next != S_IDLE);
    w_gnt_next  = (w_state_next == S_GRANT) ? w_win_mask : '0;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy  <= 1'b1;
      r_aec  <= 1'b1;
      r_busy <= 1'b0;
      r_gnt  <= '0;
    end else begin
      r_rdy  <= w_rdy_next;
      r_aec  <= w_aec_next;
      r_busy <= w_busy_next;
      r_gnt  <= w_gnt_next;
    end
  end

  // Winner latch, phase counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_winner <= C_LAST_RST;
      r_last   <= C_LAST_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (|req) r_winner <= w_win;
        end
        S_STALL: begin
          if (w_state_next == S_GRANT) r_cnt <= '0;
          else                         r_cnt <= r_cnt + C_ONE;
        end
        S_GRANT: begin
          r_cnt <= r_cnt + C_ONE;
        end
        S_RETURN: begin
          r_last <= r_winner;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign cpu_rdy     = r_rdy;
  assign cpu_aec     = r_aec;
  assign busy        = r_busy;
  assign last_winner = r_last;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Bench for bus_dma_arbiter: directed scenarios with literal expectations,
// then randomized requests and CPU cycle types checked every cycle against a
// transaction-level model, plus invariant checks on the DUT outputs.
module tb_bus_dma_arbiter;

  localparam int N_REQ     = 2;
  localparam int RDY_LEAD  = 3;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             cpu_rwn;
  logic             cpu_rdy;
  logic             cpu_aec;
  logic             busy;
  logic [1:0]       last_winner;

  always #5 clk = ~clk;

  bus_dma_arbiter #(
    .N_REQ(N_REQ), .RDY_LEAD(RDY_LEAD), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .cpu_rwn(cpu_rwn),
    .cpu_rdy(cpu_rdy), .cpu_aec(cpu_aec), .busy(busy), .last_winner(last_winner)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: which requester is being served and how far along it is.
  int m_last;     // most recent grantee
  int m_win;      // requester being served, -1 when free
  int m_halted;   // cycles the CPU has been held off so far, -1 when not halting
  int m_burst;    // granted cycles so far, -1 when not granted
  bit m_turn;     // bus handed back this cycle

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input int r, input int last);
    int c;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (last + k) % N_REQ;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int r, input int w, input bit n);
    bit still;
    if (!n) begin
      m_last = N_REQ - 1; m_win = -1; m_halted = -1; m_burst = -1; m_turn = 1'b0;
    end else begin
      still = (m_win >= 0) && (((r >> m_win) & 1) != 0);
      if (m_turn) begin
        m_last = m_win; m_win = -1; m_turn = 1'b0;
      end else if (m_burst >= 0) begin
        if (!still || (m_burst + 1 == MAX_BURST)) begin
          m_burst = -1; m_turn = 1'b1;
        end else begin
          m_burst++;
        end
      end else if (m_halted >= 0) begin
        if (!still) begin
          m_halted = -1; m_turn = 1'b1;
        end else if (w != 0 || m_halted + 1 >= RDY_LEAD) begin
          m_halted = -1; m_burst = 0;
        end else begin
          m_halted++;
        end
      end else if (r != 0) begin
        m_win = rr_pick(r, m_last); m_halted = 0;
      end
    end
  endtask

  // Apply inputs for one bus cycle; return at the following falling edge.
  task automatic step(input int r, input int w, input bit n);
    req = N_REQ'(r); cpu_rwn = w[0]; rst_n = n;
    @(posedge clk);
    model_step(r, w, n);
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model, plus output invariants.
  int         run_len  = 0;
  bit         seen_rdy = 1'b1;
  logic [N_REQ-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gnt",  int'(gnt),         (m_burst >= 0) ? (1 << m_win) : 0);
      check("m_rdy",  int'(cpu_rdy),     (m_halted < 0 && m_burst < 0 && !m_turn) ? 1 : 0);
      check("m_aec",  int'(cpu_aec),     (m_burst < 0) ? 1 : 0);
      check("m_busy", int'(busy),        (m_halted >= 0 || m_burst >= 0 || m_turn) ? 1 : 0);
      check("m_last", int'(last_winner), m_last);
      check("inv_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
      check("inv_gnt_aec", (gnt != 0 && cpu_aec) ? 1 : 0, 0);
      check("inv_aec_rdy", (!cpu_aec && cpu_rdy) ? 1 : 0, 0);
      if (gnt != 0) begin
        if (prev_gnt == 0) begin
          check("inv_rdy_between", int'(seen_rdy), 1);
          seen_rdy = 1'b0;
        end
        run_len++;
        check("inv_burst_len", (run_len <= MAX_BURST) ? 1 : 0, 1);
      end else begin
        run_len = 0;
      end
      if (cpu_rdy) seen_rdy = 1'b1;
      prev_gnt = gnt;
    end
  end

  logic [N_REQ-1:0] hist_g [0:24];
  logic             hist_r [0:24];
  int rq;
  int wv;
  bit nv;

  initial begin
    req = '0; cpu_rwn = 1'b1; rst_n = 1'b0;
    chk_en = 1'b1;
    step(0, 1, 0); step(0, 1, 0);
    check("rst_rdy", int'(cpu_rdy), 1);
    check("rst_aec", int'(cpu_aec), 1);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last", int'(last_winner), 1);

    // Read cycle: halt on cycle 1, grant on cycle 2.
    step(1, 1, 1);
    check("t1_c1_rdy", int'(cpu_rdy), 0);
    check("t1_c1_gnt", int'(gnt), 0);
    step(1, 1, 1);
    check("t1_c2_gnt", int'(gnt), 1);
    check("t1_c2_aec", int'(cpu_aec), 0);
    step(1, 1, 1);
    step(0, 1, 1);
    check("t1_ret_gnt", int'(gnt), 0);
    check("t1_ret_aec", int'(cpu_aec), 1);
    check("t1_ret_rdy", int'(cpu_rdy), 0);
    step(0, 1, 1);
    check("t1_idle_rdy", int'(cpu_rdy), 1);
    check("t1_idle_last", int'(last_winner), 0);

    // Write run holds off the grant until the lead limit.
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    check("t2_c3_gnt", int'(gnt), 0);
    step(1, 0, 1);
    check("t2_c4_gnt", int'(gnt), 1);
    step(0, 1, 1); step(0, 1, 1);
    check("t2_idle_rdy", int'(cpu_rdy), 1);
    // Write then read: grant one cycle after the read is seen.
    step(1, 0, 1); step(1, 0, 1);
    check("t2b_c2_gnt", int'(gnt), 0);
    step(1, 1, 1);
    check("t2b_c3_gnt", int'(gnt), 1);
    step(0, 1, 1); step(0, 1, 1);

    // Continuous requests from both: alternating 4-cycle bursts.
    step(0, 1, 0);
    hist_g[0] = gnt; hist_r[0] = cpu_rdy;
    for (int k = 0; k < 24; k++) begin
      step(3, 1, 1);
      hist_g[k+1] = gnt; hist_r[k+1] = cpu_rdy;
    end
    check("t3_c2_gnt",  int'(hist_g[2]),  1);
    check("t3_c5_gnt",  int'(hist_g[5]),  1);
    check("t3_c6_gnt",  int'(hist_g[6]),  0);
    check("t3_c7_rdy",  int'(hist_r[7]),  1);
    check("t3_c9_gnt",  int'(hist_g[9]),  2);
    check("t3_c12_gnt", int'(hist_g[12]), 2);
    check("t3_c13_gnt", int'(hist_g[13]), 0);
    check("t3_c16_gnt", int'(hist_g[16]), 1);

    // Request abandoned while the CPU is being halted.
    step(0, 1, 0);
    step(1, 0, 1);
    step(0, 0, 1);
    check("t4_ret_gnt", int'(gnt), 0);
    check("t4_ret_rdy", int'(cpu_rdy), 0);
    check("t4_ret_busy", int'(busy), 1);
    step(0, 1, 1);
    check("t4_idle_last", int'(last_winner), 0);
    step(3, 1, 1); step(3, 1, 1);
    check("t4_next_gnt", int'(gnt), 2);
    step(0, 1, 1); step(0, 1, 1);

    // Reset pulse in the middle of a grant.
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
    check("t5_pre_gnt", int'(gnt), 1);
    step(1, 1, 0);
    check("t5_rdy", int'(cpu_rdy), 1);
    check("t5_aec", int'(cpu_aec), 1);
    check("t5_gnt", int'(gnt), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_last", int'(last_winner), 1);

    // Randomized traffic.
    rq = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = int'($urandom_range(0, 3));
      wv = int'($urandom_range(0, 1));
      nv = ($urandom_range(0, 499) != 0);
      step(rq, wv, nv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
